// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: mode tables, polarity constants and the
// per-pixel decode bundle that travels through the sync delay line.
package vga_pkg;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef enum logic [0:0] {
    MODE_640X480 = 1'b0,
    MODE_800X600 = 1'b1
  } vga_mode_e;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;

  // Raw per-coordinate decode; all-zero is the idle/blanked state.
  typedef struct packed {
    logic hs_act;
    logic vs_act;
    logic vid;
  } vga_timing_t;

  function automatic vga_mode_t mode_timing(input vga_mode_e mode);
    vga_mode_t t;
    case (mode)
      MODE_800X600: t = '{h_active: 32'd800, h_fp: 32'd40, h_sync: 32'd128, h_bp: 32'd88,
                          v_active: 32'd600, v_fp: 32'd1,  v_sync: 32'd4,   v_bp: 32'd23,
                          hs_pol: SYNC_ACTIVE_HIGH, vs_pol: SYNC_ACTIVE_HIGH};
      default:      t = '{h_active: 32'd640, h_fp: 32'd16, h_sync: 32'd96,  h_bp: 32'd48,
                          v_active: 32'd480, v_fp: 32'd10, v_sync: 32'd2,   v_bp: 32'd33,
                          hs_pol: SYNC_ACTIVE_LOW, vs_pol: SYNC_ACTIVE_LOW};
    endcase
    return t;
  endfunction

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam vga_mode_t DEFAULT_MODE = mode_timing(MODE_640X480);

endpackage

// File: rtl/vga_timing_core_if.sv
// Renderer-facing and connector-facing signals of the VGA timing core.
interface vga_timing_core_if #(
  parameter int XY_W    = 10,
  parameter int COLOR_W = 4
) ();

  logic [COLOR_W-1:0] red_in;
  logic [COLOR_W-1:0] green_in;
  logic [COLOR_W-1:0] blue_in;
  logic [XY_W-1:0]    px;
  logic [XY_W-1:0]    py;
  logic               pix_tick;
  logic               line_end;
  logic               frame_end;
  logic               h_sync;
  logic               v_sync;
  logic               video;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic [15:0]        frame_cnt;

  modport master (
    input  red_in, green_in, blue_in,
    output px, py, pix_tick, line_end, frame_end,
    output h_sync, v_sync, video, red, green, blue, frame_cnt
  );

  modport slave (
    output red_in, green_in, blue_in,
    input  px, py, pix_tick, line_end, frame_end,
    input  h_sync, v_sync, video, red, green, blue, frame_cnt
  );

endinterface

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH enabled shift register with a reset value; DEPTH = 0 is a wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_s;
    assign unused_s = ^{clock, reset, en};
    assign dout     = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Stage 0 takes din; every other stage takes its predecessor.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= RST_VAL;
        end
      end else if (en) begin
        stage_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator: pixel divider, raster counters, delayed
// sync/blank decode and blanked, registered RGB outputs.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEFAULT_MODE.h_active,
  parameter int   H_FP     = DEFAULT_MODE.h_fp,
  parameter int   H_SYNC   = DEFAULT_MODE.h_sync,
  parameter int   H_BP     = DEFAULT_MODE.h_bp,
  parameter int   V_ACTIVE = DEFAULT_MODE.v_active,
  parameter int   V_FP     = DEFAULT_MODE.v_fp,
  parameter int   V_SYNC   = DEFAULT_MODE.v_sync,
  parameter int   V_BP     = DEFAULT_MODE.v_bp,
  parameter logic HS_POL   = DEFAULT_MODE.hs_pol,
  parameter logic VS_POL   = DEFAULT_MODE.vs_pol,
  parameter int   CLK_DIV  = 4,
  parameter int   PIPE_DLY = 2,
  parameter int   COLOR_W  = 4,
  parameter int   XY_W     = 10
) (
  input logic               clock,
  input logic               reset,
  vga_timing_core_if.master vif
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [XY_W-1:0]  H_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0]  V_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0]  H_VIS    = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0]  V_VIS    = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0]  HS_FIRST = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0]  HS_LAST  = XY_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XY_W-1:0]  VS_FIRST = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0]  VS_LAST  = XY_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]   div_r;
  logic [XY_W-1:0]    hc_r;
  logic [XY_W-1:0]    vc_r;
  logic [15:0]        frame_cnt_r;
  logic               pix_tick_s;
  logic               line_end_s;
  vga_timing_t        raw_s;
  vga_timing_t        dly_s;
  logic               h_sync_r;
  logic               v_sync_r;
  logic               video_r;
  logic [COLOR_W-1:0] red_r;
  logic [COLOR_W-1:0] green_r;
  logic [COLOR_W-1:0] blue_r;

  // With CLK_DIV = 1 the divider is pinned at zero, so the tick is constant 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  assign pix_tick_s = (div_r == DIV_LAST);
  assign line_end_s = pix_tick_s & (hc_r == H_LAST);

  // Raster position and completed-frame count advance once per pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc_r        <= {XY_W{1'b0}};
      vc_r        <= {XY_W{1'b0}};
      frame_cnt_r <= 16'd0;
    end else if (pix_tick_s) begin
      if (hc_r == H_LAST) begin
        hc_r <= {XY_W{1'b0}};
        if (vc_r == V_LAST) begin
          vc_r        <= {XY_W{1'b0}};
          frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
          vc_r <= vc_r + XY_W'(1);
        end
      end else begin
        hc_r <= hc_r + XY_W'(1);
      end
    end
  end

  // Decode of the coordinate currently shown on px/py.
  always_comb begin
    raw_s        = '{hs_act: 1'b0, vs_act: 1'b0, vid: 1'b0};
    raw_s.hs_act = (hc_r >= HS_FIRST) && (hc_r <= HS_LAST);
    raw_s.vs_act = (vc_r >= VS_FIRST) && (vc_r <= VS_LAST);
    raw_s.vid    = (hc_r < H_VIS) && (vc_r < V_VIS);
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (3'b000)
  ) u_sync_dly (
    .clock (clock),
    .reset (reset),
    .en    (pix_tick_s),
    .din   (raw_s),
    .dout  (dly_s)
  );

  // Pin register: colour is sampled on the same tick as its aligned decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_sync_r <= ~HS_POL;
      v_sync_r <= ~VS_POL;
      video_r  <= 1'b0;
      red_r    <= {COLOR_W{1'b0}};
      green_r  <= {COLOR_W{1'b0}};
      blue_r   <= {COLOR_W{1'b0}};
    end else if (pix_tick_s) begin
      h_sync_r <= dly_s.hs_act ? HS_POL : ~HS_POL;
      v_sync_r <= dly_s.vs_act ? VS_POL : ~VS_POL;
      video_r  <= dly_s.vid;
      red_r    <= dly_s.vid ? vif.red_in   : {COLOR_W{1'b0}};
      green_r  <= dly_s.vid ? vif.green_in : {COLOR_W{1'b0}};
      blue_r   <= dly_s.vid ? vif.blue_in  : {COLOR_W{1'b0}};
    end
  end

  assign vif.px        = hc_r;
  assign vif.py        = vc_r;
  assign vif.pix_tick  = pix_tick_s;
  assign vif.line_end  = line_end_s;
  assign vif.frame_end = line_end_s & (vc_r == V_LAST);
  assign vif.frame_cnt = frame_cnt_r;
  assign vif.h_sync    = h_sync_r;
  assign vif.v_sync    = v_sync_r;
  assign vif.video     = video_r;
  assign vif.red       = red_r;
  assign vif.green     = green_r;
  assign vif.blue      = blue_r;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: two reduced-raster instances (divided clock with a
// pipelined renderer, and undivided clock with positive syncs) against a model.
module tb_vga_timing_core;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int DA = 4, PA = 3;
  localparam int DB = 1, PB = 0;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks   = 0;
  int   failures = 0;
  int   ka = 0, kb = 0;
  int   hist_a [64];
  int   hist_b [64];

  always #5 clock = ~clock;

  vga_timing_core_if #(.XY_W(10), .COLOR_W(4)) if_a ();
  vga_timing_core_if #(.XY_W(10), .COLOR_W(4)) if_b ();

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DA), .PIPE_DLY(PA),
    .COLOR_W(4), .XY_W(10)
  ) dut_a (.clock(clock), .reset(reset_a), .vif(if_a));

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(DB), .PIPE_DLY(PB),
    .COLOR_W(4), .XY_W(10)
  ) dut_b (.clock(clock), .reset(reset_b), .vif(if_b));

  typedef struct {
    int px, py, fcnt, rgb;
    bit tick, le, fe, hsync, vsync, video;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after k clock edges since reset release. p pixel periods
  // have elapsed; the pins show the coordinate scanned pd+1 periods earlier,
  // coloured with whatever the renderer drove during the last completed period.
  function automatic exp_t model(input int k, input int d, input int pd,
                                 input bit hpol, input bit vpol, input int col);
    exp_t e;
    int p, q, qh, qv;
    bit hs, vs, vid;
    p      = k / d;
    e.tick = ((k % d) == d - 1);
    e.px   = p % HT;
    e.py   = (p / HT) % VT;
    e.fcnt = (p / (HT * VT)) % 65536;
    e.le   = e.tick && (e.px == HT - 1);
    e.fe   = e.le && (e.py == VT - 1);
    q      = p - 1 - pd;
    hs = 1'b0; vs = 1'b0; vid = 1'b0;
    if (q >= 0) begin
      qh  = q % HT;
      qv  = (q / HT) % VT;
      hs  = (qh >= HA + HFP) && (qh < HA + HFP + HSY);
      vs  = (qv >= VA + VFP) && (qv < VA + VFP + VSY);
      vid = (qh < HA) && (qv < VA);
    end
    e.hsync = hs ? hpol : ~hpol;
    e.vsync = vs ? vpol : ~vpol;
    e.video = vid;
    e.rgb   = vid ? col : 0;
    return e;
  endfunction

  task automatic cmp_core(input string tag, input exp_t e,
                          input logic [9:0] px, input logic [9:0] py, input logic tick,
                          input logic le, input logic fe, input logic hs, input logic vs,
                          input logic vid, input logic [11:0] rgb, input logic [15:0] fc);
    chk({tag, ".px"},        32'(px),  32'(e.px));
    chk({tag, ".py"},        32'(py),  32'(e.py));
    chk({tag, ".pix_tick"},  32'(tick), 32'(e.tick));
    chk({tag, ".line_end"},  32'(le),  32'(e.le));
    chk({tag, ".frame_end"}, 32'(fe),  32'(e.fe));
    chk({tag, ".h_sync"},    32'(hs),  32'(e.hsync));
    chk({tag, ".v_sync"},    32'(vs),  32'(e.vsync));
    chk({tag, ".video"},     32'(vid), 32'(e.video));
    chk({tag, ".rgb"},       32'(rgb), 32'(e.rgb));
    chk({tag, ".frame_cnt"}, 32'(fc),  32'(e.fcnt));
  endtask

  // Model bookkeeping: edges since release and the colour sampled at each tick.
  always @(posedge clock or posedge reset_a) begin
    if (reset_a) begin
      ka <= 0;
    end else begin
      if (ka % DA == DA - 1) hist_a[(ka / DA) % 64] <= int'({if_a.red_in, if_a.green_in, if_a.blue_in});
      ka <= ka + 1;
    end
  end

  always @(posedge clock or posedge reset_b) begin
    if (reset_b) begin
      kb <= 0;
    end else begin
      if (kb % DB == DB - 1) hist_b[(kb / DB) % 64] <= int'({if_b.red_in, if_b.green_in, if_b.blue_in});
      kb <= kb + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    exp_t ea, eb;
    ea = model(ka, DA, PA, 1'b0, 1'b0, hist_a[((ka / DA) - 1) & 63]);
    eb = model(kb, DB, PB, 1'b1, 1'b1, hist_b[((kb / DB) - 1) & 63]);
    cmp_core("a", ea, if_a.px, if_a.py, if_a.pix_tick, if_a.line_end, if_a.frame_end,
             if_a.h_sync, if_a.v_sync, if_a.video, {if_a.red, if_a.green, if_a.blue}, if_a.frame_cnt);
    cmp_core("b", eb, if_b.px, if_b.py, if_b.pix_tick, if_b.line_end, if_b.frame_end,
             if_b.h_sync, if_b.v_sync, if_b.video, {if_b.red, if_b.green, if_b.blue}, if_b.frame_cnt);
  end

  // Random renderer colour, changed just after every clock edge.
  initial begin
    logic [11:0] ca, cb;
    if_a.red_in = 4'hF; if_a.green_in = 4'hF; if_a.blue_in = 4'hF;
    if_b.red_in = 4'hF; if_b.green_in = 4'hF; if_b.blue_in = 4'hF;
    @(negedge reset_a);
    forever begin
      @(posedge clock);
      #1;
      ca = 12'($urandom_range(0, 4095));
      cb = 12'($urandom_range(0, 4095));
      if_a.red_in = ca[11:8]; if_a.green_in = ca[7:4]; if_a.blue_in = ca[3:0];
      if_b.red_in = cb[11:8]; if_b.green_in = cb[7:4]; if_b.blue_in = cb[3:0];
    end
  end

  initial begin
    int found, run;
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (3) @(negedge clock);
    // Reset held with full-scale colour in.
    chk("rst.a.h_sync", 32'(if_a.h_sync), 32'd1);
    chk("rst.a.v_sync", 32'(if_a.v_sync), 32'd1);
    chk("rst.a.video",  32'(if_a.video),  32'd0);
    chk("rst.a.red",    32'(if_a.red),    32'd0);
    chk("rst.a.px",     32'(if_a.px),     32'd0);
    chk("rst.a.tick",   32'(if_a.pix_tick), 32'd0);
    chk("rst.b.h_sync", 32'(if_b.h_sync), 32'd0);
    chk("rst.b.tick",   32'(if_b.pix_tick), 32'd1);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;

    // First tick after CLK_DIV-1 edges, first advance on edge CLK_DIV.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("start.tick3", 32'(if_a.pix_tick), 32'd1);
    chk("start.px3",   32'(if_a.px),       32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("start.px4",   32'(if_a.px),       32'd1);
    chk("start.tick4", 32'(if_a.pix_tick), 32'd0);

    // Positive h_sync at one clock per pixel: exactly HSY high clocks per line.
    found = 0;
    for (int i = 0; i < 4 * HT && found == 0; i++) begin
      @(negedge clock);
      if (if_b.px == 10'(HA + HFP)) found = 1;
    end
    chk("b.find_hs_start", 32'(found), 32'd1);
    chk("b.hs_idle", 32'(if_b.h_sync), 32'd0);
    run = 0;
    for (int i = 0; i < HT; i++) begin
      @(negedge clock);
      if (if_b.h_sync) run++;
    end
    chk("b.hs_width", 32'(run), 32'(HSY));

    // First complete frame on the divided instance.
    found = 0;
    for (int i = 0; i < 2 * HT * VT * DA && found == 0; i++) begin
      @(negedge clock);
      if (if_a.frame_end) found = 1;
    end
    chk("a.frame_end_seen", 32'(found), 32'd1);
    @(negedge clock);
    chk("a.frame_cnt1", 32'(if_a.frame_cnt), 32'd1);

    // Asynchronous mid-frame resets: values must change before any clock edge.
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(50, 700)) @(negedge clock);
      #1;
      reset_a = 1'b1;
      #1;
      chk("arst.px",       32'(if_a.px),        32'd0);
      chk("arst.py",       32'(if_a.py),        32'd0);
      chk("arst.h_sync",   32'(if_a.h_sync),    32'd1);
      chk("arst.v_sync",   32'(if_a.v_sync),    32'd1);
      chk("arst.video",    32'(if_a.video),     32'd0);
      chk("arst.rgb",      32'({if_a.red, if_a.green, if_a.blue}), 32'd0);
      chk("arst.fcnt",     32'(if_a.frame_cnt), 32'd0);
      chk("arst.tick",     32'(if_a.pix_tick),  32'd0);
      repeat ($urandom_range(1, 3)) @(negedge clock);
      #1;
      reset_a = 1'b0;
    end

    repeat (HT * VT * DA + 200) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
